// File: rtl/led_pulse_stretcher_pkg.sv
// Shared definitions for the LED / buzzer pulse drivers.
//   lps_state_e  : FSM state encoding (IDLE, ON, GAP)
//   lps_clog2    : ceil(log2(value)), for deriving counter widths
//   lps_max      : larger of two unsigned values
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } lps_state_e;

  function automatic int unsigned lps_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned lps_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_interval_timer.sv
// Interval timer: loadable down-counter used for both ON and GAP timing.
// Counts down by one per clock and rests at zero.
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   clear_i     : synchronous force to zero (highest priority)
//   load_i      : load load_val_i on the next edge
//   load_val_i  : reload value (interval length minus one)
//   zero_o      : count is zero (decoded from the count register)
module led_pulse_stretcher_interval_timer
  import led_pulse_stretcher_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// LED pulse stretcher: turns single-cycle event strobes into visible LED
// blinks of fixed on-time separated by a guaranteed off-gap. Events that
// arrive while a pulse or gap is running are queued as a saturating count,
// so every accepted event becomes exactly one blink.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   trig_in      : event strobe, one event per high cycle
//   clear_in     : synchronous abort of pulse and queue, clears overflow
//   led_out      : registered LED drive, active high
//   busy_out     : registered, high in ON or GAP
//   pending_out  : registered count of queued events not yet shown
//   overflow_out : registered sticky flag, an event was dropped at saturation
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int ON_CLOCKS   = 256,
  parameter int GAP_CLOCKS  = 256,
  parameter int CNT_W       = 8,
  parameter int MAX_PENDING = 7,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig_in,
  input  logic              clear_in,
  output logic              led_out,
  output logic              busy_out,
  output logic [PEND_W-1:0] pending_out,
  output logic              overflow_out
);

  localparam int unsigned MIN_CNT_W =
    (lps_clog2(lps_max(ON_CLOCKS, GAP_CLOCKS)) < 1) ? 1 :
     lps_clog2(lps_max(ON_CLOCKS, GAP_CLOCKS));
  localparam int unsigned MIN_PEND_W = lps_clog2(MAX_PENDING + 1);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CLOCKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CLOCKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  if (ON_CLOCKS < 1 || GAP_CLOCKS < 1 || MAX_PENDING < 1) begin : g_bad_param
    $error("led_pulse_stretcher: ON_CLOCKS, GAP_CLOCKS and MAX_PENDING must be >= 1");
  end
  if (CNT_W < MIN_CNT_W) begin : g_bad_cnt_w
    $error("led_pulse_stretcher: CNT_W too narrow for ON_CLOCKS/GAP_CLOCKS");
  end
  if (PEND_W < MIN_PEND_W) begin : g_bad_pend_w
    $error("led_pulse_stretcher: PEND_W too narrow for MAX_PENDING");
  end

  lps_state_e        state_q, state_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic              tmr_clear;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;

  logic              gap_end;
  logic              direct;
  logic              take;
  logic              add;

  led_pulse_stretcher_interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // A trigger landing on the last GAP cycle with an empty queue starts the
  // next pulse itself, so it must not also be counted into the queue.
  assign gap_end = (state_q == ST_GAP) && tmr_zero;
  assign take    = gap_end && (pend_q != '0);
  assign direct  = gap_end && (pend_q == '0) && trig_in;
  assign add     = trig_in && (state_q != ST_IDLE) && !direct;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = ON_LOAD;

    if (clear_in) begin
      state_d   = ST_IDLE;
      pend_d    = '0;
      ovf_d     = 1'b0;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig_in) begin
            state_d  = ST_ON;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
          end
        end
        ST_ON: begin
          if (tmr_zero) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            if ((pend_q != '0) || trig_in) begin
              state_d  = ST_ON;
              tmr_load = 1'b1;
              tmr_val  = ON_LOAD;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (add && take) begin
        pend_d = pend_q;
      end else if (add) begin
        if (pend_q == PEND_MAX) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end else if (take) begin
        pend_d = pend_q - 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign led_d  = (state_d == ST_ON);
  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led_out      = led_q;
  assign busy_out     = busy_q;
  assign pending_out  = pend_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher with ON_CLOCKS=4, GAP_CLOCKS=2, MAX_PENDING=3.
// Cycle N is the interval after the N-th rising edge; inputs driven in cycle N
// are sampled at the edge ending it. Expected per-cycle outputs are queued by
// the stimulus and checked by a separate monitor on the falling edge.
module tb_led_pulse_stretcher;

  logic       clk;
  logic       rst_n;
  logic       trig_in;
  logic       clear_in;
  logic       led_out;
  logic       busy_out;
  logic [1:0] pending_out;
  logic       overflow_out;

  led_pulse_stretcher #(
    .ON_CLOCKS   (4),
    .GAP_CLOCKS  (2),
    .CNT_W       (2),
    .MAX_PENDING (3),
    .PEND_W      (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trig_in      (trig_in),
    .clear_in     (clear_in),
    .led_out      (led_out),
    .busy_out     (busy_out),
    .pending_out  (pending_out),
    .overflow_out (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    bit    led;
    bit    busy;
    int    pend;
    bit    ovf;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic exp_span(input int c0, input int c1, input bit led, input bit busy,
                          input int pend, input bit ovf, input string name);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc = c; e.led = led; e.busy = busy; e.pend = pend; e.ovf = ovf; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc != cyc || led_out !== cur.led || busy_out !== cur.busy ||
          int'(pending_out) != cur.pend || overflow_out !== cur.ovf) begin
        errors++;
        $display("FAIL %s cyc %0d (exp cyc %0d): got led=%b busy=%b pend=%0d ovf=%b, want led=%b busy=%b pend=%0d ovf=%b",
                 cur.name, cyc, cur.cyc, led_out, busy_out, pending_out, overflow_out,
                 cur.led, cur.busy, cur.pend, cur.ovf);
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; trig_in = 1'b0; clear_in = 1'b0;

    exp_span(1, 9, 0, 0, 0, 0, "reset_idle");
    go_to(2); rst_n = 1'b1;

    // single trigger
    exp_span(10, 10, 0, 0, 0, 0, "t2_idle");
    exp_span(11, 14, 1, 1, 0, 0, "t2_on");
    exp_span(15, 16, 0, 1, 0, 0, "t2_gap");
    exp_span(17, 17, 0, 0, 0, 0, "t2_idle_after");
    go_to(10); trig_in = 1'b1;
    go_to(11); trig_in = 1'b0;

    // triggers at 30, 32, 33
    exp_span(30, 30, 0, 0, 0, 0, "t3_idle");
    exp_span(31, 32, 1, 1, 0, 0, "t3_on1");
    exp_span(33, 33, 1, 1, 1, 0, "t3_on1_p1");
    exp_span(34, 34, 1, 1, 2, 0, "t3_on1_p2");
    exp_span(35, 36, 0, 1, 2, 0, "t3_gap1");
    exp_span(37, 40, 1, 1, 1, 0, "t3_on2");
    exp_span(41, 42, 0, 1, 1, 0, "t3_gap2");
    exp_span(43, 46, 1, 1, 0, 0, "t3_on3");
    exp_span(47, 48, 0, 1, 0, 0, "t3_gap3");
    exp_span(49, 49, 0, 0, 0, 0, "t3_idle_after");
    go_to(30); trig_in = 1'b1;
    go_to(31); trig_in = 1'b0;
    go_to(32); trig_in = 1'b1;
    go_to(34); trig_in = 1'b0;

    // trigger held 6 cycles: saturation and sticky overflow, then clear
    exp_span(60, 60, 0, 0, 0, 0, "t4_idle");
    exp_span(61, 61, 1, 1, 0, 0, "t4_on1_p0");
    exp_span(62, 62, 1, 1, 1, 0, "t4_on1_p1");
    exp_span(63, 63, 1, 1, 2, 0, "t4_on1_p2");
    exp_span(64, 64, 1, 1, 3, 0, "t4_on1_p3");
    exp_span(65, 66, 0, 1, 3, 1, "t4_gap1_ovf");
    exp_span(67, 70, 1, 1, 2, 1, "t4_on2");
    exp_span(71, 72, 0, 1, 2, 1, "t4_gap2");
    exp_span(73, 76, 1, 1, 1, 1, "t4_on3");
    exp_span(77, 78, 0, 1, 1, 1, "t4_gap3");
    exp_span(79, 82, 1, 1, 0, 1, "t4_on4");
    exp_span(83, 84, 0, 1, 0, 1, "t4_gap4");
    exp_span(85, 90, 0, 0, 0, 1, "t4_idle_sticky");
    exp_span(91, 91, 0, 0, 0, 0, "t4_clear_idle");
    go_to(60); trig_in = 1'b1;
    go_to(66); trig_in = 1'b0;
    go_to(90); clear_in = 1'b1;
    go_to(91); clear_in = 1'b0;

    // trigger on the last GAP cycle, empty queue
    exp_span(100, 100, 0, 0, 0, 0, "t5a_idle");
    exp_span(101, 104, 1, 1, 0, 0, "t5a_on1");
    exp_span(105, 106, 0, 1, 0, 0, "t5a_gap1");
    exp_span(107, 110, 1, 1, 0, 0, "t5a_on2_direct");
    exp_span(111, 112, 0, 1, 0, 0, "t5a_gap2");
    exp_span(113, 113, 0, 0, 0, 0, "t5a_idle_after");
    go_to(100); trig_in = 1'b1;
    go_to(101); trig_in = 1'b0;
    go_to(106); trig_in = 1'b1;
    go_to(107); trig_in = 1'b0;

    // trigger on the last GAP cycle with two queued
    exp_span(120, 120, 0, 0, 0, 0, "t5b_idle");
    exp_span(121, 121, 1, 1, 0, 0, "t5b_on1_p0");
    exp_span(122, 122, 1, 1, 1, 0, "t5b_on1_p1");
    exp_span(123, 124, 1, 1, 2, 0, "t5b_on1_p2");
    exp_span(125, 126, 0, 1, 2, 0, "t5b_gap1");
    exp_span(127, 130, 1, 1, 2, 0, "t5b_on2_hold");
    exp_span(131, 132, 0, 1, 2, 0, "t5b_gap2");
    exp_span(133, 136, 1, 1, 1, 0, "t5b_on3");
    exp_span(137, 138, 0, 1, 1, 0, "t5b_gap3");
    exp_span(139, 142, 1, 1, 0, 0, "t5b_on4");
    exp_span(143, 144, 0, 1, 0, 0, "t5b_gap4");
    exp_span(145, 145, 0, 0, 0, 0, "t5b_idle_after");
    go_to(120); trig_in = 1'b1;
    go_to(123); trig_in = 1'b0;
    go_to(126); trig_in = 1'b1;
    go_to(127); trig_in = 1'b0;

    // clear with coincident trigger during ON, pending=2, overflow=1
    exp_span(150, 150, 0, 0, 0, 0, "t6_idle");
    exp_span(151, 151, 1, 1, 0, 0, "t6_on1_p0");
    exp_span(152, 152, 1, 1, 1, 0, "t6_on1_p1");
    exp_span(153, 153, 1, 1, 2, 0, "t6_on1_p2");
    exp_span(154, 154, 1, 1, 3, 0, "t6_on1_p3");
    exp_span(155, 156, 0, 1, 3, 1, "t6_gap1");
    exp_span(157, 158, 1, 1, 2, 1, "t6_on2");
    exp_span(159, 166, 0, 0, 0, 0, "t6_cleared");
    go_to(150); trig_in = 1'b1;
    go_to(156); trig_in = 1'b0;
    go_to(158); trig_in = 1'b1; clear_in = 1'b1;
    go_to(159); trig_in = 1'b0; clear_in = 1'b0;

    // asynchronous reset in ON cycle 2
    exp_span(200, 200, 0, 0, 0, 0, "t1_idle");
    exp_span(201, 201, 1, 1, 0, 0, "t1_on");
    exp_span(202, 209, 0, 0, 0, 0, "t1_async_reset");
    exp_span(210, 210, 0, 0, 0, 0, "t1_idle_after");
    exp_span(211, 211, 1, 1, 0, 0, "t1_on_after_reset");
    go_to(200); trig_in = 1'b1;
    go_to(201); trig_in = 1'b0;
    go_to(202); rst_n = 1'b0;
    go_to(204); rst_n = 1'b1;
    go_to(210); trig_in = 1'b1;
    go_to(211); trig_in = 1'b0;

    waited = 0;
    while (sb.size() > 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
